mem_port_arbiter: RTL

Shares one single-ported, variable-latency memory between the instruction-fetch stage and the MEM stage of the 64-bit RISC-V pipeline. It replaces the separate instruction and data memory paths. It grants one requester at a time, holds the transaction until the memory acknowledges, and returns the read data with a one-cycle valid pulse. It also drives per-stage stall signals so the pipeline registers freeze while their access is outstanding.

---
 rtl/mem_arb_pkg.sv | 16 +
 rtl/arb_starve_counter.sv | 38 +++
 rtl/mem_port_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the instruction/data memory port arbiter.
package mem_arb_pkg;

  // Default widths for the 64-bit pipeline.
  localparam int unsigned ARB_ADDR_W = 64;
  localparam int unsigned ARB_DATA_W = 64;
  localparam int unsigned INST_W     = 32;

  // Arbiter state.
  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Saturating counter of consecutive data grants made while fetch is waiting.
// Raises at_limit once the count reaches LIMIT.
module arb_starve_counter #(
  parameter int unsigned LIMIT = 4,
  parameter int unsigned CNT_W = $clog2(LIMIT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority; increment saturates at LIMIT.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != CNT_W'(LIMIT))) begin
      count_d = count_q + 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign at_limit = (count_q == CNT_W'(LIMIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported variable-latency memory between instruction fetch and the MEM
// stage. Data has priority; one transaction outstanding at a time; read data is returned
// with a one-cycle valid pulse.
// Optional feature: define STARVE_GUARD_EN to force a fetch grant after STARVE_LIMIT
// consecutive data grants made while fetch was waiting.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W       = ARB_ADDR_W,
  parameter int unsigned DATA_W       = ARB_DATA_W,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // Instruction fetch
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [INST_W-1:0] if_rdata,
  output logic              if_valid,
  // Data access
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_valid,
  // Memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  // Pipeline stalls
  output logic              stall_if,
  output logic              stall_mem
);

  arb_state_e        state_q, state_d;
  logic              mem_req_d, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic [INST_W-1:0] if_rdata_d;
  logic [DATA_W-1:0] d_rdata_d;
  logic              if_valid_d, d_valid_d;

  logic              take_fetch;
  logic              grant_i, grant_d;

`ifdef STARVE_GUARD_EN
  logic starve_at_limit;

  // Fetch wins when data is absent or when data has starved it for STARVE_LIMIT grants.
  assign take_fetch = if_req & (~d_req | starve_at_limit);

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve_counter (
    .clk      (clk),
    .reset    (reset),
    .inc      (grant_d & if_req),
    .clr      (grant_i | (grant_d & ~if_req)),
    .at_limit (starve_at_limit)
  );
`else
  // Strict data priority.
  assign take_fetch = if_req & ~d_req;
`endif

  assign grant_i = (state_q == ARB_IDLE) & take_fetch;
  assign grant_d = (state_q == ARB_IDLE) & d_req & ~take_fetch;

  // Next-state and registered-output logic; everything holds unless changed below.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req;
    mem_we_d    = mem_we;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;
    if_valid_d  = 1'b0;
    d_valid_d   = 1'b0;

    unique case (state_q)
      ARB_IDLE: begin
        // A stray mem_ack here is ignored.
        if (grant_d) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          state_d     = ARB_BUSY_D;
        end else if (grant_i) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          state_d     = ARB_BUSY_I;
        end
      end
      ARB_BUSY_I: begin
        if (mem_ack) begin
          mem_req_d  = 1'b0;
          if_rdata_d = mem_rdata[INST_W-1:0];
          if_valid_d = 1'b1;
          state_d    = ARB_IDLE;
        end
      end
      ARB_BUSY_D: begin
        if (mem_ack) begin
          mem_req_d = 1'b0;
          // Stores leave the load-data register untouched.
          if (!mem_we) begin
            d_rdata_d = mem_rdata;
          end
          d_valid_d = 1'b1;
          state_d   = ARB_IDLE;
        end
      end
      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset abandons any outstanding transaction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_valid  <= 1'b0;
      d_valid   <= 1'b0;
    end else begin
      state_q   <= state_d;
      mem_req   <= mem_req_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
      if_valid  <= if_valid_d;
      d_valid   <= d_valid_d;
    end
  end

  assign stall_if  = if_req & ~if_valid;
  assign stall_mem = d_req & ~d_valid;

endmodule
